gp_regfile: RTL

//  Parametrised general-purpose register file; successor to the single GP register.
//  - NREG registers of WIDTH bits, loaded from the shared tri-state bus.
//  - Any register can be driven back onto the bus.
//  - A secondary operand-latch stage feeds the ALU left/right inputs through tri-state outputs.
//  - Adds in-place increment/decrement with a wrap flag, used for counter and pointer registers.

---
 rtl/gp_regfile.sv | 98 +++++++++
 1 files changed

// File: rtl/gp_regfile.sv
// General-purpose register file: NREG x WIDTH registers on a shared tri-state bus,
// with ALU operand latches and in-place increment/decrement with a wrap flag.
module gp_regfile #(
    parameter int WIDTH = 8,
    parameter int NREG = 4,
    localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loadn,
    input  logic [SEL_W-1:0] load_sel,
    input  logic             outn,
    input  logic [SEL_W-1:0] out_sel,
    input  logic             latchn,
    input  logic [SEL_W-1:0] l_sel,
    input  logic [SEL_W-1:0] r_sel,
    input  logic             loutn,
    input  logic             routn,
    input  logic             incn,
    input  logic             decn,
    input  logic [SEL_W-1:0] cnt_sel,
    inout  wire  [WIDTH-1:0] bus,
    output wire  [WIDTH-1:0] alu_l,
    output wire  [WIDTH-1:0] alu_r,
    output logic             wrap
);

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] lat_l, lat_r;

    logic [WIDTH-1:0] out_val, l_val, r_val, c_val;
    logic             cnt_valid;

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        out_val   = '0;
        l_val     = '0;
        r_val     = '0;
        c_val     = '0;
        cnt_valid = 1'b0;
        // Selectors with no matching register fall through to 0.
        for (int i = 0; i < NREG; i++) begin
            if (out_sel == SEL_W'(i)) out_val = regs[i];
            if (l_sel == SEL_W'(i))   l_val   = regs[i];
            if (r_sel == SEL_W'(i))   r_val   = regs[i];
            if (cnt_sel == SEL_W'(i)) begin
                c_val     = regs[i];
                cnt_valid = 1'b1;
            end
        end
    end

    logic             load_en, cnt_en, cnt_up, load_wins;
    logic [WIDTH-1:0] cnt_next;
    logic             cnt_wrap, wrap_next;

    always_comb begin
        load_en   = !loadn;
        // Both inc and dec requested cancel each other out.
        cnt_en    = incn ^ decn;
        cnt_up    = !incn;
        load_wins = load_en && (load_sel == cnt_sel);
        cnt_next  = cnt_up ? c_val + WIDTH'(1) : c_val - WIDTH'(1);
        cnt_wrap  = cnt_up ? (&c_val) : ~(|c_val);
        wrap_next = cnt_en && cnt_valid && !load_wins && cnt_wrap;
    end

    // NOTE: the register array is cleared by reset like any other state; a reset-free
    // RAM would leave stale contents visible on the bus after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            lat_l <= '0;
            lat_r <= '0;
            wrap  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates mean the latches sample pre-edge register values
            // even when the same register is loaded on this edge.
            if (!latchn) begin
                lat_l <= l_val;
                lat_r <= r_val;
            end
            for (int i = 0; i < NREG; i++) begin
                if (load_en && load_sel == SEL_W'(i))
                    regs[i] <= bus;
                else if (cnt_en && cnt_sel == SEL_W'(i))
                    regs[i] <= cnt_next;
            end
            wrap <= wrap_next;
        end
    end

    assign bus   = !outn  ? out_val : 'z;
    assign alu_l = !loutn ? lat_l   : 'z;
    assign alu_r = !routn ? lat_r   : 'z;

endmodule
